// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// Module      : fetch_stage
// Description : TSC CPU instruction fetch: PC, I-memory handshake, IF/ID register.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 16'h0000,
    parameter logic [WORD_SIZE-1:0] NOP_INSTR = 16'hF03F
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_write,
    input  logic                 ir_write,
    input  logic                 stall_IFID,
    input  logic                 flush_IFID,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    output logic [WORD_SIZE-1:0] pc_IFID,
    output logic [WORD_SIZE-1:0] pc_plus1_IFID,
    output logic [WORD_SIZE-1:0] instr_IFID,
    output logic                 valid_IFID,
    output logic                 fetch_busy
);

    localparam logic [WORD_SIZE-1:0] c_one = WORD_SIZE'(1);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t               r_state;
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_hold_buf;
    logic [WORD_SIZE-1:0] r_hold_pc;

    logic                 w_advance;
    logic [WORD_SIZE-1:0] w_pc_plus1;
    logic [WORD_SIZE-1:0] w_hold_plus1;

    assign w_advance    = ir_write & ~stall_IFID & ~flush_IFID;
    assign w_pc_plus1   = r_pc + c_one;
    assign w_hold_plus1 = r_hold_pc + c_one;

    // Request is level-held while in FETCH; reset masks it even if state is stale.
    assign i_readM    = ~reset & (r_state == S_FETCH);
    assign i_address  = r_pc;
    assign fetch_busy = i_readM & ~i_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_hold_buf    <= '0;
            r_hold_pc     <= '0;
            pc_IFID       <= '0;
            pc_plus1_IFID <= '0;
            instr_IFID    <= NOP_INSTR;
            valid_IFID    <= 1'b0;
        end else if (redirect_valid) begin
            // Any word returned this cycle belongs to the wrong path and is dropped.
            r_state    <= S_FETCH;
            r_pc       <= redirect_pc;
            instr_IFID <= NOP_INSTR;
            valid_IFID <= 1'b0;
        end else if (flush_IFID) begin
            r_state    <= S_FETCH;
            instr_IFID <= NOP_INSTR;
            valid_IFID <= 1'b0;
        end else if (r_state == S_HOLD) begin
            if (w_advance) begin
                pc_IFID       <= r_hold_pc;
                pc_plus1_IFID <= w_hold_plus1;
                instr_IFID    <= r_hold_buf;
                valid_IFID    <= 1'b1;
                r_state       <= S_FETCH;
                if (pc_write) begin
                    r_pc <= w_hold_plus1;
                end
            end
        end else begin
            if (i_ready && w_advance) begin
                pc_IFID       <= r_pc;
                pc_plus1_IFID <= w_pc_plus1;
                instr_IFID    <= i_data;
                valid_IFID    <= 1'b1;
                if (pc_write) begin
                    r_pc <= w_pc_plus1;
                end
            end else if (i_ready) begin
                // IF/ID not accepting: park the word so memory need not re-serve it.
                r_hold_buf <= i_data;
                r_hold_pc  <= r_pc;
                r_state    <= S_HOLD;
            end else if (w_advance) begin
                instr_IFID <= NOP_INSTR;
                valid_IFID <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage with a behavioural fetch model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

    localparam logic [15:0] c_nop      = 16'hF03F;
    localparam logic [15:0] c_reset_pc = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_write = 1'b0;
    logic        ir_write = 1'b0;
    logic        stall_IFID = 1'b0;
    logic        flush_IFID = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data = '0;
    logic        i_ready = 1'b0;
    logic [15:0] pc_IFID;
    logic [15:0] pc_plus1_IFID;
    logic [15:0] instr_IFID;
    logic        valid_IFID;
    logic        fetch_busy;

    fetch_stage #(
        .WORD_SIZE (16),
        .RESET_PC  (c_reset_pc),
        .NOP_INSTR (c_nop)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_write       (pc_write),
        .ir_write       (ir_write),
        .stall_IFID     (stall_IFID),
        .flush_IFID     (flush_IFID),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .i_readM        (i_readM),
        .i_address      (i_address),
        .i_data         (i_data),
        .i_ready        (i_ready),
        .pc_IFID        (pc_IFID),
        .pc_plus1_IFID  (pc_plus1_IFID),
        .instr_IFID     (instr_IFID),
        .valid_IFID     (valid_IFID),
        .fetch_busy     (fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        readm;
        logic [15:0] addr;
        logic        busy;
        logic [15:0] pc;
        logic [15:0] pc1;
        logic [15:0] instr;
        logic        valid;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: fetch pointer, optional parked instruction, IF/ID contents.
    logic [15:0] m_pc       = c_reset_pc;
    bit          m_parked   = 1'b0;
    logic [15:0] m_park_pc  = '0;
    logic [15:0] m_ifid_pc  = '0;
    logic [15:0] m_ifid_pc1 = '0;
    logic [15:0] m_ifid_ins = c_nop;
    logic        m_ifid_v   = 1'b0;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic deliver(input logic [15:0] a);
        m_ifid_pc  = a;
        m_ifid_pc1 = a + 16'd1;
        m_ifid_ins = mem(a);
        m_ifid_v   = 1'b1;
    endtask

    task automatic bubble();
        m_ifid_ins = c_nop;
        m_ifid_v   = 1'b0;
    endtask

    task automatic cycle(input bit r, input bit rv, input logic [15:0] rpc, input bit fl,
                         input bit st, input bit irw, input bit pcw, input bit rdy);
        exp_t e;
        bit   take;
        @(negedge clk);
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        flush_IFID     = fl;
        stall_IFID     = st;
        ir_write       = irw;
        pc_write       = pcw;
        i_ready        = rdy;
        i_data         = rdy ? mem(i_address) : 16'($urandom);

        e.readm = !r && !m_parked;
        e.addr  = m_pc;
        e.busy  = e.readm && !rdy;

        take = irw && !st && !fl;
        if (r) begin
            m_pc = c_reset_pc; m_parked = 1'b0;
            m_ifid_pc = '0; m_ifid_pc1 = '0; bubble();
        end else if (rv) begin
            m_pc = rpc; m_parked = 1'b0; bubble();
        end else if (fl) begin
            m_parked = 1'b0; bubble();
        end else if (m_parked) begin
            if (take) begin
                deliver(m_park_pc);
                m_parked = 1'b0;
                if (pcw) m_pc = m_park_pc + 16'd1;
            end
        end else if (rdy) begin
            if (take) begin
                deliver(m_pc);
                if (pcw) m_pc = m_pc + 16'd1;
            end else begin
                m_parked  = 1'b1;
                m_park_pc = m_pc;
            end
        end else if (take) begin
            bubble();
        end

        e.pc    = m_ifid_pc;
        e.pc1   = m_ifid_pc1;
        e.instr = m_ifid_ins;
        e.valid = m_ifid_v;
        q.push_back(e);
    endtask

    task automatic run(input bit rdy);
        cycle(0, 0, 16'h0, 0, 0, 1, 1, rdy);
    endtask

    task automatic stall(input bit rdy);
        cycle(0, 0, 16'h0, 0, 1, 0, 0, rdy);
    endtask

    // Monitor: combinational outputs just before the edge, IF/ID just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("i_readM",    {15'd0, i_readM},    {15'd0, e.readm});
                check("i_address",  i_address,           e.addr);
                check("fetch_busy", {15'd0, fetch_busy}, {15'd0, e.busy});
                @(posedge clk);
                #1;
                check("valid_IFID",    {15'd0, valid_IFID}, {15'd0, e.valid});
                check("instr_IFID",    instr_IFID,          e.instr);
                check("pc_IFID",       pc_IFID,             e.pc);
                check("pc_plus1_IFID", pc_plus1_IFID,       e.pc1);
            end
        end
    end

    initial begin
        cycle(1, 0, 16'h0, 0, 0, 0, 0, 0);
        cycle(1, 0, 16'h0, 0, 0, 0, 0, 1);
        // Straight-line then a 3-cycle wait at PC 5
        repeat (5) run(1);
        repeat (3) run(0);
        run(1);
        // Load-use stall at PC 8
        repeat (2) run(1);
        repeat (2) stall(1);
        repeat (2) run(1);
        // Branch miss while parked
        stall(1);
        cycle(0, 1, 16'h0040, 1, 0, 1, 1, 1);
        repeat (2) run(1);
        // Redirect during stall wins
        cycle(0, 1, 16'h1234, 0, 1, 0, 0, 1);
        repeat (2) run(1);
        // PC wrap
        cycle(0, 1, 16'hFFFF, 1, 0, 1, 1, 0);
        repeat (3) run(1);
        // Reset while parked
        stall(1);
        cycle(1, 0, 16'h0, 0, 1, 0, 0, 1);
        repeat (3) run(1);

        for (int i = 0; i < 600; i++) begin
            int  k;
            int  mode;
            bit  r, rv, fl, st, irw, pcw, rdy;
            k    = $urandom_range(0, 99);
            mode = $urandom_range(0, 9);
            r    = (k < 2);
            rv   = (k >= 2 && k < 9);
            fl   = rv ? 1'($urandom_range(0, 1)) : (k >= 9 && k < 13);
            st   = (mode == 7 || mode == 8);
            irw  = (mode < 7);
            pcw  = irw;
            rdy  = ($urandom_range(0, 3) != 0);
            cycle(r, rv, 16'($urandom), fl, st, irw, pcw, rdy);
        end

        repeat (2) @(posedge clk);
        #3;
        check("scoreboard_drain", 16'(q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined TSC CPU: owns the PC, drives the instruction-memory read handshake, and loads the IF/ID pipeline register. It directly consumes the hazard control unit's `pc_write`, `ir_write`, `stall_IFID` and `flush_IFID` outputs. It also takes the corrected target from branch/jump resolution. Prediction is always-not-taken (PC+1); any redirect comes from downstream.

## Interface
- `WORD_SIZE`, 16, data/address width.
- `RESET_PC`, 16'h0000, PC value after reset.
- `NOP_INSTR`, 16'hF03F, bubble encoding (opcode 15, undefined func; decodes as no instruction type).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `pc_write` in 1: PC may advance (hazard unit).
- `ir_write` in 1: IF/ID may load a new instruction (hazard unit).
- `stall_IFID` in 1: hold IF/ID contents.
- `flush_IFID` in 1: replace IF/ID with bubble.
- `redirect_valid` in 1: misprediction resolved; load `redirect_pc`.
- `redirect_pc` in 16: corrected fetch target.
- `i_readM` out 1: instruction read request.
- `i_address` out 16: fetch address.
- `i_data` in 16: instruction word, valid when `i_ready`=1.
- `i_ready` in 1: memory returns data this cycle for the current `i_address`.
- `pc_IFID` out 16: PC of the IF/ID instruction.
- `pc_plus1_IFID` out 16: `pc_IFID`+1, used as the JAL/JRL link value.
- `instr_IFID` out 16: IF/ID instruction.
- `valid_IFID` out 1: IF/ID holds a real instruction.
- `fetch_busy` out 1: fetch waiting on memory; high in FETCH with `i_ready`=0.

## Operation
- State machine: FETCH (request outstanding) and HOLD (word captured, IF/ID not accepting).
- `advance` = `ir_write` & !`stall_IFID` & !`flush_IFID`.
- Priority: reset > `redirect_valid` > `flush_IFID` > stall/hold > normal.
- FETCH: `i_readM`=1, `i_address`=`pc`.
  - `i_ready` & `advance`: IF/ID loads {`pc`, `pc`+1, `i_data`, valid=1}. PC becomes `pc`+1 if `pc_write`. State stays FETCH.
  - `i_ready` & !`advance` & !flush: `hold_buf`/`hold_pc` capture the word and `pc`. State goes to HOLD. PC does not advance.
  - !`i_ready` & `advance`: IF/ID loads a bubble (valid=0, `instr_IFID`=`NOP_INSTR`, pc fields unchanged). PC is unchanged.
  - `stall_IFID`=1: IF/ID retains its contents in every case.
- HOLD: `i_readM`=0. When `advance`, IF/ID loads `hold_buf`, PC becomes `hold_pc`+1 (gated by `pc_write`), and the state returns to FETCH.
- `redirect_valid`: `pc`←`redirect_pc`. IF/ID takes a bubble. `hold_buf` is discarded. State goes to FETCH. Any `i_data` returned in the same cycle is dropped. This applies regardless of `stall_IFID` and `pc_write`.
- `flush_IFID` without redirect: IF/ID takes a bubble. A word returned that cycle is dropped and not held. PC is unchanged. State goes to FETCH.
- PC arithmetic is modulo 2^16; 16'hFFFF+1 wraps to 16'h0000.
- Memory contract: a request is level-held. The memory must accept an address change at any cycle, and `i_ready` refers to the current `i_address` only.

## Timing
- Reset values: `pc`=`RESET_PC`, state FETCH, `valid_IFID`=0, `instr_IFID`=`NOP_INSTR`, `pc_IFID`=0, `pc_plus1_IFID`=0, `hold_buf`=0.
  - `i_readM`=0 while `reset` is high, and 1 from the first cycle after reset.
- `i_readM`, `i_address` and `fetch_busy` are combinational from state and `pc` (plus `i_ready` for busy). All IF/ID outputs are registered.
- Latency: with `i_ready` returned the same cycle, the instruction at PC p appears on `instr_IFID` at the next edge. Throughput is 1 per cycle.
- N-cycle memory wait produces N bubbles downstream (when not stalled).
- Redirect in cycle t: `i_address`=`redirect_pc` in cycle t+1. The first valid IF/ID is at t+2 (1-cycle memory).
- Reset mid-wait or in HOLD: the buffered word is lost and fetch restarts at `RESET_PC`.

## Test plan
- Straight-line: reset, `RESET_PC`=0, 1-cycle memory returning 16'h1000+addr → `instr_IFID` = 16'h1000, 16'h1001, 16'h1002 on consecutive cycles, all valid, `pc_plus1_IFID`=`pc_IFID`+1.
- Memory wait: `i_ready` low 3 cycles at PC 5 → `fetch_busy`=1 for 3 cycles, 3 bubbles (valid=0, `NOP_INSTR`), then instr@5 with `pc_IFID`=5, no duplicate or skip.
- Load-use stall: `stall_IFID`=1, `pc_write`=0, `ir_write`=0 for 2 cycles while `i_ready`=1 at PC 8 → IF/ID holds instr@7, state HOLD, `i_readM`=0. On release, instr@8 loads and PC=9.
- Branch miss: `redirect_valid`=1, `flush_IFID`=1, `redirect_pc`=16'h0040 while in HOLD → bubble, `hold_buf` discarded, next `i_address`=16'h0040, then valid instr@0x40.
- Redirect while stalled: `redirect_valid` & `stall_IFID` in the same cycle → PC=`redirect_pc` and bubble (redirect wins).
- Wrap and reset: PC 16'hFFFF fetch → next `i_address`=16'h0000. Assert `reset` in HOLD → all outputs at reset values on the next edge.
